// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked write arbiter in front of a
// single-clock store-buffer FIFO. It tracks FIFO occupancy itself, counting
// writes still in flight, so it never writes into a full FIFO.
module fifo_wr_arbiter #(
   parameter int NUM_PORTS   = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH_WIDTH = 10
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PORTS-1:0]              req_valid_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_data_i,
   input  logic [NUM_PORTS-1:0]              req_last_i,
   output logic [NUM_PORTS-1:0]              req_ready_o,
   output logic [NUM_PORTS-1:0]              grant_o,
   output logic [DATA_WIDTH-1:0]             fifo_wr_data_o,
   output logic                              fifo_wr_en_o,
   input  logic                              fifo_rd_en_i,
   input  logic                              fifo_full_i,
   output logic [DEPTH_WIDTH:0]              fifo_level_o,
   output logic                              err_o
);

   localparam int PTR_W = $clog2(NUM_PORTS);
   localparam logic [PTR_W:0]       NP_W      = (PTR_W+1)'(NUM_PORTS);
   localparam logic [DEPTH_WIDTH:0] LEVEL_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};
   localparam logic [DEPTH_WIDTH:0] LEVEL_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};
   localparam logic [NUM_PORTS-1:0] ONE_HOT   = {{(NUM_PORTS-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                 state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       owner;
   logic                   sel_found;
   logic [PTR_W-1:0]       sel_idx;
   logic [PTR_W-1:0]       cand;
   logic [DATA_WIDTH-1:0]  beat_data;
   logic                   beat_last;
   logic                   has_room;
   logic                   accept;

   // Port index plus one, wrapping modulo NUM_PORTS (NUM_PORTS need not be a power of two).
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
      logic [PTR_W:0] sum;
      sum = {1'b0, idx} + {{PTR_W{1'b0}}, 1'b1};
      if (sum >= NP_W) begin
         sum = sum - NP_W;
      end else begin
         sum = sum;
      end
      return sum[PTR_W-1:0];
   endfunction

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = rr_ptr;
      cand      = rr_ptr;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!sel_found && req_valid_i[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end else begin
            sel_found = sel_found;
         end
         cand = wrap_inc(cand);
      end
   end

   // Route the granted port's beat data and last flag.
   always_comb begin
      beat_data = {DATA_WIDTH{1'b0}};
      beat_last = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant_o[p]) begin
            beat_data = req_data_i[p*DATA_WIDTH +: DATA_WIDTH];
            beat_last = req_last_i[p];
         end else begin
            beat_last = beat_last;
         end
      end
   end

   // A full level blocks acceptance even if a read frees a slot this same cycle.
   assign has_room    = (fifo_level_o < LEVEL_MAX);
   assign req_ready_o = ((state == BURST) && has_room) ? (grant_o & req_valid_i)
                                                      : {NUM_PORTS{1'b0}};
   assign accept      = |req_ready_o;

   // Arbitration FSM: grant in IDLE, hold the grant for a whole packet in BURST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= {PTR_W{1'b0}};
         owner   <= {PTR_W{1'b0}};
         grant_o <= {NUM_PORTS{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  state   <= BURST;
                  owner   <= sel_idx;
                  grant_o <= ONE_HOT << sel_idx;
               end else begin
                  grant_o <= {NUM_PORTS{1'b0}};
               end
            end
            BURST: begin
               if (accept && beat_last) begin
                  state   <= IDLE;
                  grant_o <= {NUM_PORTS{1'b0}};
                  rr_ptr  <= wrap_inc(owner);
               end else begin
                  state   <= BURST;
               end
            end
            default: begin
               state   <= IDLE;
               grant_o <= {NUM_PORTS{1'b0}};
            end
         endcase
      end
   end

   // Registered FIFO write port; data holds its last value between writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_wr_en_o   <= 1'b0;
         fifo_wr_data_o <= {DATA_WIDTH{1'b0}};
      end else begin
         fifo_wr_en_o <= accept;
         if (accept) begin
            fifo_wr_data_o <= beat_data;
         end else begin
            fifo_wr_data_o <= fifo_wr_data_o;
         end
      end
   end

   // Occupancy counter: accepted beats minus reads, saturating at zero on underflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_level_o <= {(DEPTH_WIDTH+1){1'b0}};
      end else begin
         case ({accept, fifo_rd_en_i})
            2'b10: fifo_level_o <= fifo_level_o + LEVEL_ONE;
            2'b01: begin
               if (fifo_level_o != {(DEPTH_WIDTH+1){1'b0}}) begin
                  fifo_level_o <= fifo_level_o - LEVEL_ONE;
               end else begin
                  fifo_level_o <= fifo_level_o;
               end
            end
            default: fifo_level_o <= fifo_level_o;
         endcase
      end
   end

   // Sticky error: write into a full FIFO or read from an empty one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_o <= 1'b0;
      end else begin
         if ((fifo_rd_en_i && (fifo_level_o == {(DEPTH_WIDTH+1){1'b0}})) ||
             (fifo_wr_en_o && fifo_full_i)) begin
            err_o <= 1'b1;
         end else begin
            err_o <= err_o;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed stimulus, a behavioural model
// checked every cycle, and literal expectations at key points.
module tb_fifo_wr_arbiter;

   localparam int NP  = 4;
   localparam int DW  = 16;
   localparam int DPW = 2;
   localparam int CAP = 4;

   logic              clk;
   logic              rst;
   logic [NP-1:0]     req_valid;
   logic [NP*DW-1:0]  req_data;
   logic [NP-1:0]     req_last;
   logic [NP-1:0]     req_ready;
   logic [NP-1:0]     grant;
   logic [DW-1:0]     wr_data;
   logic              wr_en;
   logic              rd_en;
   logic              full;
   logic [DPW:0]      level;
   logic              err;

   int n_checks = 0;
   int n_err    = 0;

   fifo_wr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEPTH_WIDTH(DPW)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid),
      .req_data_i     (req_data),
      .req_last_i     (req_last),
      .req_ready_o    (req_ready),
      .grant_o        (grant),
      .fifo_wr_data_o (wr_data),
      .fifo_wr_en_o   (wr_en),
      .fifo_rd_en_i   (rd_en),
      .fifo_full_i    (full),
      .fifo_level_o   (level),
      .err_o          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_owner;   // -1 when no port holds the grant
   int          m_ptr;
   int          m_level;
   bit          m_err;
   bit          m_wr_en;
   logic [DW-1:0] m_wr_data;

   function automatic logic [NP-1:0] exp_ready();
      logic [NP-1:0] r;
      r = '0;
      if (m_owner >= 0) begin
         if (req_valid[m_owner] && (m_level < CAP)) r[m_owner] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [NP-1:0] exp_grant();
      logic [NP-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   // Model state update from the rules: grant, accept, write, count, error.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner   <= -1;
         m_ptr     <= 0;
         m_level   <= 0;
         m_err     <= 1'b0;
         m_wr_en   <= 1'b0;
         m_wr_data <= '0;
      end else begin : step
         int  nxt_owner;
         int  nxt_ptr;
         int  lvl;
         bit  acc;
         acc = 1'b0;
         if (m_owner >= 0) acc = req_valid[m_owner] && (m_level < CAP);
         nxt_owner = m_owner;
         nxt_ptr   = m_ptr;
         if (m_owner < 0) begin
            for (int k = 0; k < NP; k++) begin
               if (nxt_owner < 0 && req_valid[(m_ptr + k) % NP]) nxt_owner = (m_ptr + k) % NP;
            end
         end else if (acc && req_last[m_owner]) begin
            nxt_owner = -1;
            nxt_ptr   = (m_owner + 1) % NP;
         end
         lvl = m_level + (acc ? 1 : 0) - (rd_en ? 1 : 0);
         if (lvl < 0) lvl = 0;
         m_err   <= m_err | (rd_en && m_level == 0) | (m_wr_en && full);
         m_wr_en <= acc;
         if (acc) m_wr_data <= req_data[m_owner*DW +: DW];
         m_owner <= nxt_owner;
         m_ptr   <= nxt_ptr;
         m_level <= lvl;
      end
   end

   // Compare DUT outputs against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("grant",   32'(grant),     32'(exp_grant()));
         check("ready",   32'(req_ready), 32'(exp_ready()));
         check("wr_en",   32'(wr_en),     32'(m_wr_en));
         check("wr_data", 32'(wr_data),   32'(m_wr_data));
         check("level",   32'(level),     32'(m_level));
         check("err",     32'(err),       32'(m_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      rd_en     = 1'b0;
      full      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_beat(input int p, input logic [DW-1:0] d, input logic l);
      req_valid[p]         = 1'b1;
      req_data[p*DW +: DW] = d;
      req_last[p]          = l;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_grant"},   32'(grant),     32'h0);
      check({tag, "_ready"},   32'(req_ready), 32'h0);
      check({tag, "_wr_en"},   32'(wr_en),     32'h0);
      check({tag, "_wr_data"}, 32'(wr_data),   32'h0);
      check({tag, "_level"},   32'(level),     32'h0);
      check({tag, "_err"},     32'(err),       32'h0);
   endtask

   logic [NP-1:0] grant_seq [0:8];

   initial begin
      rst = 1'b1;
      clear_inputs();

      // Test 1: port 1 sends a 3-beat packet A1, A2, A3.
      do_reset();
      check_reset_values("rst");
      check("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
      set_beat(1, 16'h00A1, 1'b0);
      tick();
      check("t1_grant", 32'(grant), 32'h2);
      check("t1_ready", 32'(req_ready), 32'h2);
      tick();
      check("t1_wr1_en", 32'(wr_en), 32'h1);
      check("t1_wr1_data", 32'(wr_data), 32'hA1);
      set_beat(1, 16'h00A2, 1'b0);
      tick();
      check("t1_wr2_en", 32'(wr_en), 32'h1);
      check("t1_wr2_data", 32'(wr_data), 32'hA2);
      set_beat(1, 16'h00A3, 1'b1);
      tick();
      check("t1_wr3_en", 32'(wr_en), 32'h1);
      check("t1_wr3_data", 32'(wr_data), 32'hA3);
      check("t1_grant_clear", 32'(grant), 32'h0);
      check("t1_rr_ptr", 32'(dut.rr_ptr), 32'h2);
      check("t1_model_ptr", 32'(m_ptr), 32'h2);
      req_valid = '0;
      req_last  = '0;
      tick();
      check("t1_wr_done", 32'(wr_en), 32'h0);
      check("t1_level", 32'(level), 32'h3);
      check("t1_model_level", 32'(m_level), 32'h3);

      // Test 2: all ports request 1-beat packets continuously.
      do_reset();
      for (int p = 0; p < NP; p++) set_beat(p, 16'(16'h00B0 + p), 1'b1);
      grant_seq[0] = 4'b0001; grant_seq[1] = 4'b0000; grant_seq[2] = 4'b0010;
      grant_seq[3] = 4'b0000; grant_seq[4] = 4'b0100; grant_seq[5] = 4'b0000;
      grant_seq[6] = 4'b1000; grant_seq[7] = 4'b0000; grant_seq[8] = 4'b0001;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("t2_grant%0d", i), 32'(grant), 32'(grant_seq[i]));
      end

      // Test 3: port 0 streams into a 4-entry FIFO with no reads.
      do_reset();
      set_beat(0, 16'h00C0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         req_data[0 +: DW] = 16'(16'h00C1 + i);
      end
      check("t3_level_full", 32'(level), 32'h4);
      check("t3_ready_full", 32'(req_ready), 32'h0);
      check("t3_grant_hold", 32'(grant), 32'h1);
      check("t3_no_write", 32'(wr_en), 32'h0);
      rd_en = 1'b1;
      #1;
      check("t3_ready_full_rd", 32'(req_ready), 32'h0);
      tick();
      rd_en = 1'b0;
      check("t3_level_after_rd", 32'(level), 32'h3);
      check("t3_ready_room", 32'(req_ready), 32'h1);
      tick();
      check("t3_level_refill", 32'(level), 32'h4);
      check("t3_one_more_write", 32'(wr_en), 32'h1);
      check("t3_ready_again_0", 32'(req_ready), 32'h0);
      tick();
      check("t3_no_extra_write", 32'(wr_en), 32'h0);
      check("t3_err", 32'(err), 32'h0);
      req_valid = '0;

      // Test 4: accept and read in the same cycle at level 2.
      do_reset();
      set_beat(2, 16'h00D1, 1'b0);
      tick();
      tick();
      set_beat(2, 16'h00D2, 1'b0);
      tick();
      check("t4_level2", 32'(level), 32'h2);
      set_beat(2, 16'h00D3, 1'b1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      req_valid = '0;
      check("t4_level_same", 32'(level), 32'h2);
      check("t4_wr_data", 32'(wr_data), 32'hD3);
      check("t4_err", 32'(err), 32'h0);

      // Test 5: read at level 0 sets a sticky error.
      do_reset();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t5_level0", 32'(level), 32'h0);
      check("t5_err_set", 32'(err), 32'h1);
      tick(); tick(); tick();
      check("t5_err_sticky", 32'(err), 32'h1);
      do_reset();
      check("t5_err_cleared", 32'(err), 32'h0);

      // Test 6: write while the FIFO reports full sets the error.
      do_reset();
      set_beat(0, 16'h00E1, 1'b1);
      full = 1'b1;
      tick();
      tick();
      req_valid = '0;
      check("t6_wr_en", 32'(wr_en), 32'h1);
      tick();
      full = 1'b0;
      check("t6_err_full", 32'(err), 32'h1);

      // Test 7: asynchronous reset during the 2nd beat of a 4-beat packet.
      do_reset();
      set_beat(2, 16'h00F1, 1'b0);
      tick();
      tick();
      set_beat(2, 16'h00F2, 1'b0);
      check("t7_pre_wr_en", 32'(wr_en), 32'h1);
      check("t7_pre_level", 32'(level), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check_reset_values("t7_async");
      clear_inputs();
      tick();
      rst = 1'b0;
      check("t7_rr_ptr", 32'(dut.rr_ptr), 32'h0);
      set_beat(3, 16'h0033, 1'b1);
      tick();
      check("t7_grant3", 32'(grant), 32'h8);
      tick();
      req_valid = '0;
      check("t7_wr_data", 32'(wr_data), 32'h33);
      check("t7_rr_wrap", 32'(dut.rr_ptr), 32'h0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
